// File: rtl/mgmt_cmd_sequencer_if.sv
// Requester-side and management_module-side signal bundle for mgmt_cmd_sequencer.
// The slave modport is the sequencer's view; master is the host/model view.
interface mgmt_cmd_sequencer_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_cc;
  logic [33*NUM_REQ-1:0] req_param;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [31:0]           rsp_rc;
  logic                  busy;
  logic [31:0]           mm_tpm_cc;
  logic [32:0]           mm_cmd_param;
  logic [7:0]            mm_locality;
  logic                  mm_keyStart_n;
  logic [31:0]           mm_tpm_rc;
  logic [2:0]            mm_op_state;

  modport slave (
    input  req, req_cc, req_param, mm_tpm_rc, mm_op_state,
    output gnt, done, rsp_rc, busy, mm_tpm_cc, mm_cmd_param, mm_locality, mm_keyStart_n
  );

  modport master (
    output req, req_cc, req_param, mm_tpm_rc, mm_op_state,
    input  gnt, done, rsp_rc, busy, mm_tpm_cc, mm_cmd_param, mm_locality, mm_keyStart_n
  );
endinterface

// File: rtl/mgmt_cmd_sequencer.sv
// Round-robin TPM command sequencer in front of management_module with a timed keyStart_n strobe.
// Optional MGMT_SEQ_TIMEOUT_EN: SETTLE waits for an op_state change, with a watchdog fallback.
//
// state  | meaning
// IDLE   | waiting for any request; arbitrates from ptr upward
// SETUP  | cc/param/locality driven and stable before the strobe
// STROBE | keyStart_n held low
// SETTLE | keyStart_n high, tpm_rc sampled on the last cycle
// DONE   | one-cycle done pulse to the winner, gnt dropped
module mgmt_cmd_sequencer #(
  parameter int NUM_REQ        = 4,
  parameter int SETUP_CYCLES   = 4,
  parameter int STROBE_CYCLES  = 6,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clock,
  input logic reset_n,
  mgmt_cmd_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  localparam logic [31:0] RC_FAILURE = 32'h0000_0101;

  state_t               state_q, state_nxt;
  logic [7:0]           cnt_q, cnt_nxt;
  logic [2:0]           ptr_q, ptr_nxt;
  logic [NUM_REQ-1:0]   gnt_q, gnt_nxt;
  logic [NUM_REQ-1:0]   done_q, done_nxt;
  logic [31:0]          rc_q, rc_nxt;
  logic [31:0]          cc_q, cc_nxt;
  logic [32:0]          param_q, param_nxt;
  logic [7:0]           loc_q, loc_nxt;
  logic                 ks_q, ks_nxt;
  logic                 busy_q;

  logic                 found;
  int                   pick;
  int                   idx;
  logic [NUM_REQ-1:0]   req_sh;
  logic [32*NUM_REQ-1:0] cc_sh;
  logic [33*NUM_REQ-1:0] param_sh;
  logic                 settle_end;
  logic [31:0]          settle_rc;

`ifdef MGMT_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT_CYCLES - 1);
  logic [2:0] snap_q, snap_nxt;
  logic [7:0] wd_q, wd_nxt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_op_state;
  assign unused_op_state = ^bus.mm_op_state;
`endif

  // First set request at or above ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    pick   = 0;
    idx    = 0;
    req_sh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx    = (int'(ptr_q) + i) % NUM_REQ;
      req_sh = bus.req >> idx;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    cc_sh    = bus.req_cc >> (32 * pick);
    param_sh = bus.req_param >> (33 * pick);
  end

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    ptr_nxt    = ptr_q;
    gnt_nxt    = gnt_q;
    done_nxt   = '0;
    rc_nxt     = rc_q;
    cc_nxt     = cc_q;
    param_nxt  = param_q;
    loc_nxt    = loc_q;
    ks_nxt     = 1'b1;
    settle_end = 1'b0;
    settle_rc  = bus.mm_tpm_rc;
`ifdef MGMT_SEQ_TIMEOUT_EN
    snap_nxt   = snap_q;
    wd_nxt     = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_nxt = S_SETUP;
          cnt_nxt   = SETUP_LD;
          gnt_nxt   = NUM_REQ'(1) << pick;
          cc_nxt    = cc_sh[31:0];
          param_nxt = param_sh[32:0];
          loc_nxt   = 8'(pick);
          ptr_nxt   = 3'((pick + 1) % NUM_REQ);
`ifdef MGMT_SEQ_TIMEOUT_EN
          snap_nxt  = bus.mm_op_state;
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_nxt = S_STROBE;
          cnt_nxt   = STROBE_LD;
          ks_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt_q - 8'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 8'd0) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = SETTLE_LD;
`ifdef MGMT_SEQ_TIMEOUT_EN
          wd_nxt    = TIMEOUT_LD;
`endif
        end else begin
          cnt_nxt = cnt_q - 8'd1;
          ks_nxt  = 1'b0;
        end
      end
      S_SETTLE: begin
`ifdef MGMT_SEQ_TIMEOUT_EN
        // Minimum settle time first, then wait for the module to report progress.
        if (cnt_q == 8'd0 && bus.mm_op_state != snap_q) begin
          settle_end = 1'b1;
        end else if (wd_q == 8'd0) begin
          settle_end = 1'b1;
          settle_rc  = RC_FAILURE;
        end else begin
          wd_nxt = wd_q - 8'd1;
          if (cnt_q != 8'd0) cnt_nxt = cnt_q - 8'd1;
        end
`else
        if (cnt_q == 8'd0) settle_end = 1'b1;
        else               cnt_nxt    = cnt_q - 8'd1;
`endif
        if (settle_end) begin
          state_nxt = S_DONE;
          rc_nxt    = settle_rc;
          done_nxt  = gnt_q;
          gnt_nxt   = '0;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ptr_q   <= 3'd0;
      gnt_q   <= '0;
      done_q  <= '0;
      rc_q    <= 32'd0;
      cc_q    <= 32'd0;
      param_q <= 33'd0;
      loc_q   <= 8'd0;
      ks_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef MGMT_SEQ_TIMEOUT_EN
      snap_q  <= 3'd0;
      wd_q    <= 8'd0;
`endif
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      ptr_q   <= ptr_nxt;
      gnt_q   <= gnt_nxt;
      done_q  <= done_nxt;
      rc_q    <= rc_nxt;
      cc_q    <= cc_nxt;
      param_q <= param_nxt;
      loc_q   <= loc_nxt;
      ks_q    <= ks_nxt;
      busy_q  <= (state_nxt != S_IDLE);
`ifdef MGMT_SEQ_TIMEOUT_EN
      snap_q  <= snap_nxt;
      wd_q    <= wd_nxt;
`endif
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.done          = done_q;
  assign bus.rsp_rc        = rc_q;
  assign bus.busy          = busy_q;
  assign bus.mm_tpm_cc     = cc_q;
  assign bus.mm_cmd_param  = param_q;
  assign bus.mm_locality   = loc_q;
  assign bus.mm_keyStart_n = ks_q;

endmodule

// File: tb/tb_mgmt_cmd_sequencer.sv
// Directed bench for mgmt_cmd_sequencer: reset, single command timing, round-robin,
// latch stability, dropped request, error capture and (with MGMT_SEQ_TIMEOUT_EN) watchdog.
module tb_mgmt_cmd_sequencer;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  logic op_follow = 1'b1;
  logic [2:0] op_cnt = 3'd0;

  mgmt_cmd_sequencer_if #(.NUM_REQ(4)) bus ();

  mgmt_cmd_sequencer #(
    .NUM_REQ(4), .SETUP_CYCLES(4), .STROBE_CYCLES(6), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Management module model: op_state advances each time a strobe starts.
  always @(negedge bus.mm_keyStart_n) if (op_follow) op_cnt <= op_cnt + 3'd1;
  assign bus.mm_op_state = op_cnt;

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req = '0;
    bus.req_cc = '0;
    bus.req_param = '0;
    bus.mm_tpm_rc = 32'h0;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.gnt !== 4'b0 || bus.done !== 4'b0 || bus.busy !== 1'b0 || bus.mm_keyStart_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_init: gnt=%b done=%b busy=%b ks=%b want 0000 0000 0 1",
               bus.gnt, bus.done, bus.busy, bus.mm_keyStart_n);
    end
    reset_n = 1'b1;
    @(negedge clock);
    bus.req_cc[31:0] = 32'h0000_0055;
    bus.req_param[32:0] = 33'h1_0000_0003;
    bus.mm_tpm_rc = 32'h0000_0077;
    bus.req = 4'b0001;
    repeat (6) @(negedge clock);
    checks++;
    if (bus.mm_keyStart_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_pre_strobe: ks=%b want 0", bus.mm_keyStart_n);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.mm_keyStart_n !== 1'b1 || bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: ks=%b gnt=%b busy=%b want 1 0000 0", bus.mm_keyStart_n, bus.gnt, bus.busy);
    end
    bus.req = '0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.gnt !== 4'b0 || bus.done !== 4'b0 || bus.busy !== 1'b0 || bus.mm_keyStart_n !== 1'b1 ||
        bus.rsp_rc !== 32'h0 || bus.mm_tpm_cc !== 32'h0 || bus.mm_cmd_param !== 33'h0 ||
        bus.mm_locality !== 8'h0) begin
      failures++;
      $display("FAIL reset_release: gnt=%b done=%b busy=%b ks=%b rc=%h cc=%h param=%h loc=%h want all reset values",
               bus.gnt, bus.done, bus.busy, bus.mm_keyStart_n, bus.rsp_rc, bus.mm_tpm_cc,
               bus.mm_cmd_param, bus.mm_locality);
    end
  endtask

  task automatic test_single();
    int first_low = -1;
    int low_cnt = 0;
    int done_cyc = -1;
    do_reset();
    bus.req_cc = '0;
    bus.req_param = '0;
    bus.req_cc[63:32] = 32'h0000_0144;
    bus.mm_tpm_rc = 32'h0;
    bus.req = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (c == 1) begin
        checks++;
        if (bus.gnt !== 4'b0010 || bus.mm_locality !== 8'd1 || bus.mm_tpm_cc !== 32'h144 || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL single_grant: gnt=%b loc=%0d cc=%h busy=%b want 0010 1 00000144 1",
                   bus.gnt, bus.mm_locality, bus.mm_tpm_cc, bus.busy);
        end
      end
      if (bus.mm_keyStart_n === 1'b0) begin
        if (first_low < 0) first_low = c;
        low_cnt++;
      end
      if (bus.done !== 4'b0 && done_cyc < 0) begin
        done_cyc = c;
        bus.req = '0;
        checks++;
        if (bus.done !== 4'b0010 || bus.gnt !== 4'b0 || bus.rsp_rc !== 32'h0) begin
          failures++;
          $display("FAIL single_done: done=%b gnt=%b rc=%h want 0010 0000 00000000", bus.done, bus.gnt, bus.rsp_rc);
        end
      end
    end
    checks++;
    if (first_low !== 5 || low_cnt !== 6) begin
      failures++;
      $display("FAIL single_strobe: first_low=%0d low_cycles=%0d want 5 6", first_low, low_cnt);
    end
    checks++;
    if (done_cyc !== 15) begin
      failures++;
      $display("FAIL single_latency: done_cycle=%0d want 15", done_cyc);
    end
    checks++;
    if (bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle_after: gnt=%b busy=%b want 0000 0", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[4] = '{0, 1, 3, 0};
    logic [3:0] want;
    int n;
    do_reset();
    bus.mm_tpm_rc = 32'h0;
    bus.req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      want = 4'b0001 << exp_seq[k];
      n = 0;
      while (bus.gnt === 4'b0 && n < 40) begin
        @(negedge clock);
        n++;
      end
      checks++;
      if (bus.gnt !== want) begin
        failures++;
        $display("FAIL rr_grant_%0d: gnt=%b want %b", k, bus.gnt, want);
      end
      n = 0;
      while (bus.done === 4'b0 && n < 40) begin
        @(negedge clock);
        n++;
      end
      checks++;
      if (bus.done !== want) begin
        failures++;
        $display("FAIL rr_done_%0d: done=%b want %b", k, bus.done, want);
      end
      @(negedge clock);
      checks++;
      if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.done !== 4'b0) begin
        failures++;
        $display("FAIL rr_idle_gap_%0d: gnt=%b busy=%b done=%b want 0000 0 0000", k, bus.gnt, bus.busy, bus.done);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_param_stability();
    int bad = 0;
    do_reset();
    bus.req_cc = '0;
    bus.req_cc[31:0] = 32'h0000_0144;
    bus.req = 4'b0001;
    repeat (6) @(negedge clock);
    bus.req_cc[31:0] = 32'hDEAD_BEEF;
    for (int c = 6; c <= 15; c++) begin
      if (bus.mm_tpm_cc !== 32'h144) bad++;
      if (c < 15) @(negedge clock);
    end
    checks++;
    if (bad !== 0 || bus.done !== 4'b0001) begin
      failures++;
      $display("FAIL param_hold: bad_cycles=%0d done=%b want 0 0001", bad, bus.done);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.mm_tpm_cc !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL param_relatch: gnt=%b cc=%h want 0001 deadbeef", bus.gnt, bus.mm_tpm_cc);
    end
    bus.req = '0;
  endtask

  task automatic test_drop_req();
    int done_cyc = -1;
    do_reset();
    bus.req = 4'b1000;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clock);
      if (c == 3) bus.req = '0;
      if (bus.done === 4'b1000 && done_cyc < 0) done_cyc = c;
      if (c == 2) begin
        checks++;
        if (bus.mm_locality !== 8'd3 || bus.gnt !== 4'b1000) begin
          failures++;
          $display("FAIL drop_grant: loc=%0d gnt=%b want 3 1000", bus.mm_locality, bus.gnt);
        end
      end
    end
    checks++;
    if (done_cyc !== 15) begin
      failures++;
      $display("FAIL drop_done: done_cycle=%0d want 15", done_cyc);
    end
  endtask

  task automatic test_error_capture();
    int n = 0;
    do_reset();
    bus.req_param = '0;
    bus.req_param[98:66] = 33'h1;
    bus.mm_tpm_rc = 32'h0000_0084;
    bus.req = 4'b0100;
    @(negedge clock);
    checks++;
    if (bus.mm_cmd_param !== 33'h1 || bus.mm_locality !== 8'd2) begin
      failures++;
      $display("FAIL err_latch: param=%h loc=%0d want 000000001 2", bus.mm_cmd_param, bus.mm_locality);
    end
    while (bus.done === 4'b0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    bus.req = '0;
    checks++;
    if (bus.done !== 4'b0100 || bus.rsp_rc !== 32'h84) begin
      failures++;
      $display("FAIL err_rc: done=%b rc=%h want 0100 00000084", bus.done, bus.rsp_rc);
    end
    bus.mm_tpm_rc = 32'h0;
    repeat (5) @(negedge clock);
    checks++;
    if (bus.rsp_rc !== 32'h84 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL err_rc_hold: rc=%h busy=%b want 00000084 0", bus.rsp_rc, bus.busy);
    end
  endtask

`ifdef MGMT_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int done_cyc = -1;
    do_reset();
    op_follow = 1'b0;
    bus.mm_tpm_rc = 32'h0000_0055;
    bus.req = 4'b0001;
    for (int c = 1; c <= 90 && done_cyc < 0; c++) begin
      @(negedge clock);
      if (bus.done !== 4'b0) done_cyc = c;
    end
    bus.req = '0;
    checks++;
    if (done_cyc !== 75 || bus.rsp_rc !== 32'h101) begin
      failures++;
      $display("FAIL timeout: done_cycle=%0d rc=%h want 75 00000101", done_cyc, bus.rsp_rc);
    end
    op_follow = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_param_stability();
    test_drop_req();
    test_error_capture();
`ifdef MGMT_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mgmt_cmd_sequencer.md
Name: mgmt_cmd_sequencer

Overview:
Sequences TPM commands into the single management_module instance and shares it among up to five locality requesters. Each requester presents a command code and parameter. The block arbitrates round-robin, drives the management module's tpm_cc, cmd_param and locality inputs, generates the active-low keyStart_n strobe with fixed setup and hold timing, then captures tpm_rc and returns it to the winning requester. It sits between the host interface/locality decoder and management_module.

Parameters:
NUM_REQ, 4, number of requesters (1..5); requester index is the locality
SETUP_CYCLES, 4, cycles cc/param are stable before the strobe (1..255)
STROBE_CYCLES, 6, cycles keyStart_n is held low (1..255)
SETTLE_CYCLES, 4, cycles after the strobe before tpm_rc is sampled (1..255)
TIMEOUT_CYCLES, 64, watchdog limit, used only with the optional feature (1..255)

Ports:
clock  in  1  system clock; all logic is on the rising edge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  request per locality; held high until done
req_cc  in  32*NUM_REQ  command code, slice i = bits [32i+31:32i]
req_param  in  33*NUM_REQ  command parameter, slice i = bits [33i+32:33i]
gnt  out  NUM_REQ  one-hot grant, high for the whole operation
done  out  NUM_REQ  one-cycle completion pulse to the granted requester
rsp_rc  out  32  response code, valid from the done pulse until the next done
busy  out  1  high in any state other than IDLE
mm_tpm_cc  out  32  to management_module tpm_cc
mm_cmd_param  out  33  to management_module cmd_param
mm_locality  out  8  to management_module locality (granted index, zero-extended)
mm_keyStart_n  out  1  to management_module keyStart_n
mm_tpm_rc  in  32  from management_module tpm_rc
mm_op_state  in  3  from management_module op_state

Behaviour:
- Reset (async, reset_n=0): state IDLE; gnt=0; done=0; rsp_rc=0; busy=0; mm_keyStart_n=1; mm_tpm_cc=0; mm_cmd_param=0; mm_locality=0; rr pointer=0; counter=0.
- All outputs are registered.
- FSM states: IDLE, SETUP, STROBE, SETTLE, DONE.
- IDLE: when any req bit is 1, grant the first set bit found by searching from index ptr upward with wrap. Next cycle:
  - state becomes SETUP;
  - gnt is one-hot;
  - mm_tpm_cc and mm_cmd_param are latched from the winner's slice;
  - mm_locality = winner index;
  - ptr = (winner+1) mod NUM_REQ.
- SETUP: lasts exactly SETUP_CYCLES, then STROBE.
- STROBE: mm_keyStart_n=0 for exactly STROBE_CYCLES, then SETTLE.
- SETTLE: mm_keyStart_n=1 for SETTLE_CYCLES. On the last cycle, mm_tpm_rc is sampled into rsp_rc. Next state is DONE.
- DONE (1 cycle): done[winner]=1 and gnt=0 in this cycle. Next state is IDLE.
- Total latency from req high in IDLE to the done pulse = 1+SETUP+STROBE+SETTLE cycles (15 with defaults).
- Command inputs are latched once. Changes to req_cc/req_param during an operation have no effect.
- req dropped mid-operation: the operation completes unchanged and done still pulses.
- A new req arriving during an operation waits. At least one IDLE cycle always separates the done pulse and the next grant.
- A requester still holding req in IDLE after its done is treated as a new request and is arbitrated fairly via ptr.
- rsp_rc holds until the next capture. It is not cleared by IDLE.
- Counter is 8 bits, loaded with N-1 on state entry, and decrements to 0.

Optional Feature:
Macro MGMT_SEQ_TIMEOUT_EN.
- Defined:
  - mm_op_state is sampled on entry to SETUP.
  - SETTLE waits at least SETTLE_CYCLES, then additionally until mm_op_state differs from the sampled value.
  - If TIMEOUT_CYCLES elapse in SETTLE without a change, rsp_rc = 32'h00000101 (TPM_RC_FAILURE) instead of mm_tpm_rc, and the FSM proceeds to DONE.
- Undefined: SETTLE is fixed-length; mm_op_state is unused; TIMEOUT_CYCLES is ignored.

Test Plan:
- Reset check: reset_n=0 mid-STROBE -> mm_keyStart_n=1, gnt=0, busy=0 immediately (asynchronous). After release, the FSM is in IDLE with all outputs at reset values.
- Single command: req[1]=1 with cc=32'h00000144, param=0; management module returns rc=0.
  - gnt=4'b0010 one cycle later.
  - mm_locality=8'd1.
  - keyStart_n low exactly 6 cycles, starting 5 cycles after req.
  - done[1] pulses at cycle 15.
  - rsp_rc=32'h00000000.
- Round-robin: req=4'b1011 held continuously -> grant order is 0,1,3,0 with one IDLE cycle between operations.
- Parameter stability: change req_cc[0] during STROBE -> mm_tpm_cc keeps the latched 32'h00000144 until the next grant.
- Error capture: startup with param=33'h1 and orderly=0 such that mm_tpm_rc=32'h00000084 -> rsp_rc=32'h00000084 at done.
- With MGMT_SEQ_TIMEOUT_EN, mm_op_state held constant -> done pulses after 1+4+6+64 cycles with rsp_rc=32'h00000101.
